// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell sequenced LSB-first over WIDTH bits.
// Computes a - b - bin_in with a start/busy/done handshake; results are held in registers.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_diff;
  logic             cell_bor;
  logic [WIDTH-1:0] sr_shift;

  assign cell_diff = sa_q[0] ^ sb_q[0] ^ br_q;
  assign cell_bor  = (~sa_q[0] & br_q) | (~sa_q[0] & sb_q[0]) | (sb_q[0] & br_q);
  assign sr_shift  = {cell_diff, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE so back-to-back runs lose no extra cycle
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_shift;
        br_d  = cell_bor;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = sr_shift;
          bout_d  = cell_bor;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: cycle-level arithmetic model checked every cycle (WIDTH=8),
// directed literal cases, randomized traffic, and an exhaustive WIDTH=4 sweep.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       bin_in;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow_out;

  logic       start4;
  logic [3:0] a4, b4;
  logic       bin4;
  logic       busy4, done4;
  logic [3:0] diff4;
  logic       bout4;

  int total = 0;
  int bad   = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin_in(bin_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: an accepted request finishes WIDTH edges later with plain arithmetic results.
  logic       m_run, m_done, m_rb, m_bout;
  int         m_rem;
  logic [7:0] m_res, m_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      m_res <= '0; m_rb <= 1'b0; m_diff <= '0; m_bout <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (start) begin
          m_run <= 1'b1;
          m_rem <= 8;
          m_res <= 8'(a - b - 8'(bin_in));
          m_rb  <= ({1'b0, a} < ({1'b0, b} + 9'(bin_in)));
        end
      end else if (m_rem == 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_diff <= m_res;
        m_bout <= m_rb;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("diff", diff, m_diff);
    chk("borrow_out", borrow_out, m_bout);
    chk("busy_and_done", busy & done, 1'b0);
  end

  task automatic run8(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic [7:0] ed, input logic eb,
                      input logic chkmid, input logic [7:0] md, input logic mb);
    int n, nb;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_; bin_in = tc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin_in = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      if (busy) nb++;
      if (chkmid && n == 3) begin
        chk({nm, "_mid_diff"}, diff, md);
        chk({nm, "_mid_bout"}, borrow_out, mb);
      end
      n++;
    end
    chk({nm, "_done_seen"}, done, 1'b1);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_bout"}, borrow_out, eb);
    chk({nm, "_busy_cycles"}, nb, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, last, gap_bad, nd;
    logic [7:0] gdiff;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin_in = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bout", borrow_out, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run8("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, '0, 1'b0);
    run8("t0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, '0, 1'b0);
    run8("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, '0, 1'b0);
    run8("t100f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    run8("thold", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0);

    // start pulsed during RUN must be ignored
    @(posedge clk); #1;
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; a = 8'h11; b = 8'h22; bin_in = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    nd = 0; gdiff = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin nd++; gdiff = diff; end
    end
    chk("ignore_ndone", nd, 1);
    chk("ignore_diff", gdiff, 8'h1E);

    // start held high continuously
    @(posedge clk); #1;
    start = 1'b1; a = 8'h80; b = 8'h01; bin_in = 1'b0;
    ndone = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk("cont_diff", diff, 8'h7F);
        chk("cont_bout", borrow_out, 1'b0);
        if (last >= 0) chk("cont_gap", i - last, 9);
        last = i;
        ndone++;
      end
    end
    chk("cont_ndone", ndone, 4);
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);

    // reset in the middle of RUN
    #1;
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_diff", diff, 8'h00);
    chk("mrst_bout", borrow_out, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mrst_no_done", nd, 0);
    run8("tpost", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, '0, 1'b0);

    // randomized traffic, including starts while busy
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 3) == 0);
      a      = 8'($urandom);
      b      = 8'($urandom);
      bin_in = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);

    // exhaustive WIDTH=4 sweep
    for (int unsigned ai = 0; ai < 16; ai++) begin
      for (int unsigned bi = 0; bi < 16; bi++) begin
        for (int unsigned ci = 0; ci < 2; ci++) begin
          int n;
          @(posedge clk); #1;
          start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci);
          @(posedge clk); #1;
          start4 = 1'b0;
          n = 0;
          while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
          end
          chk("w4_done_seen", done4, 1'b1);
          chk("w4_diff", diff4, 4'((ai + 16 - bi - ci) % 16));
          chk("w4_bout", bout4, (ai < bi + ci) ? 1'b1 : 1'b0);
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
